// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, reset/NOP constants,
// and the pc/inst packet carried through the skid slot.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bundle: I-cache request/response, redirect, decode stall and IF/ID register.
// master = fetch unit side, slave = surrounding pipeline / cache side.
interface if_fetch_unit_if;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic [31:0] ic_resp_data;
  logic        ic_resp_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;

  modport master (
    output ic_req_valid, ic_req_addr, if_id_valid, if_id_pc, if_id_inst,
    input  ic_resp_data, ic_resp_ready, redirect_valid, redirect_pc, id_stall
  );

  modport slave (
    input  ic_req_valid, ic_req_addr, if_id_valid, if_id_pc, if_id_inst,
    output ic_resp_data, ic_resp_ready, redirect_valid, redirect_pc, id_stall
  );
endinterface

// File: rtl/if_fetch_unit_skid_slot.sv
// One-entry pc/inst holding register for a fetch that completes while decode is stalled.
// Latency: contents visible the cycle after load.
// Backpressure: none internally; the owner only loads when empty and unloads when full.
module if_skid_slot
  import if_fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       unload,
  input  logic       clear,
  input  fetch_pkt_t load_pkt,
  output fetch_pkt_t pkt,
  output logic       full
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full <= 1'b0;
      pkt  <= '0;
    end else if (load) begin
      full <= 1'b1;
      pkt  <= load_pkt;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the pc, issues one I-cache request at a time, fills IF/ID.
// Latency: instruction on if_id_* the cycle after ic_resp_ready.
// Backpressure: id_stall parks one completed fetch in the skid slot and suspends requests.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  if_fetch_unit_if.master bus
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic [31:0]  pc_next_seq;
  logic [31:0]  redirect_tgt;
  logic         slot_free;
  logic         fetch_done;
  logic         skid_load;
  logic         skid_unload;
  logic         skid_full;
  fetch_pkt_t   skid_in;
  fetch_pkt_t   skid_pkt;

  assign redirect_tgt = align_pc(bus.redirect_pc);
  assign pc_next_seq  = pc + 32'd4;
  assign slot_free    = !bus.if_id_valid || !bus.id_stall;
  assign fetch_done   = (state == ST_FETCH) && bus.ic_resp_ready && !bus.redirect_valid;
  assign skid_load    = fetch_done && !slot_free;
  assign skid_unload  = (state == ST_HOLD) && skid_full && !bus.redirect_valid && !bus.id_stall;
  assign skid_in      = '{pc: req_addr, inst: bus.ic_resp_data};

  // A request stays visible in DISCARD: the cache cannot abort it, so it must be drained.
  assign bus.ic_req_valid = (state == ST_FETCH) || (state == ST_DISCARD);
  assign bus.ic_req_addr  = req_addr;

  if_skid_slot u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (bus.redirect_valid),
    .load_pkt (skid_in),
    .pkt      (skid_pkt),
    .full     (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      pc              <= RESET_PC;
      req_addr        <= RESET_PC;
      bus.if_id_valid <= 1'b0;
      bus.if_id_pc    <= 32'h0;
      bus.if_id_inst  <= NOP_INST;
    end else begin
      // Decode took the current instruction; anything reloaded below overrides this.
      if (!bus.id_stall) begin
        bus.if_id_valid <= 1'b0;
        bus.if_id_inst  <= NOP_INST;
      end
      if (bus.redirect_valid) begin
        bus.if_id_valid <= 1'b0;
        bus.if_id_inst  <= NOP_INST;
        pc              <= redirect_tgt;
        case (state)
          ST_IDLE, ST_HOLD: begin
            state    <= ST_FETCH;
            req_addr <= redirect_tgt;
          end
          ST_FETCH, ST_DISCARD: begin
            if (bus.ic_resp_ready) begin
              state    <= ST_FETCH;
              req_addr <= redirect_tgt;
            end else begin
              state    <= ST_DISCARD;
            end
          end
        endcase
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_FETCH;
            req_addr <= pc;
          end
          ST_FETCH: begin
            if (bus.ic_resp_ready) begin
              pc       <= pc_next_seq;
              req_addr <= pc_next_seq;
              if (slot_free) begin
                bus.if_id_valid <= 1'b1;
                bus.if_id_pc    <= req_addr;
                bus.if_id_inst  <= bus.ic_resp_data;
              end else begin
                state <= ST_HOLD;
              end
            end
          end
          ST_HOLD: begin
            if (skid_unload) begin
              bus.if_id_valid <= 1'b1;
              bus.if_id_pc    <= skid_pkt.pc;
              bus.if_id_inst  <= skid_pkt.inst;
              state           <= ST_FETCH;
              req_addr        <= pc;
            end
          end
          ST_DISCARD: begin
            if (bus.ic_resp_ready) begin
              state    <= ST_FETCH;
              req_addr <= pc;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: scripted I-cache stub plus request and IF/ID scoreboards.
// Latency: expectations are queued per step and popped when the cache completes or IF/ID loads.
// Backpressure: id_stall and cache ready are driven directly by the directed steps.
module tb_if_fetch_unit;

  localparam logic [31:0] TB_NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic cache_block = 1'b0;
  int   cache_lat = 1;
  logic [31:0] exp_req[$];
  logic [31:0] exp_if[$];

  if_fetch_unit_if bus();

  if_fetch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5C3_0003;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, {31'b0, bus.ic_req_valid}, 32'd0);
    check({tag, "_req_addr"}, bus.ic_req_addr, 32'h0);
    check({tag, "_if_id_valid"}, {31'b0, bus.if_id_valid}, 32'd0);
    check({tag, "_if_id_pc"}, bus.if_id_pc, 32'h0);
    check({tag, "_if_id_inst"}, bus.if_id_inst, TB_NOP);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.id_stall = 1'b0;
    step();
    step();
    check_reset_vals("rst");
    tests++;
    assert (exp_req.size() == 0 && exp_if.size() == 0) else begin
      fails++;
      $error("FAIL rst_pending: observed %0d/%0d queued expectations, expected 0/0",
             exp_req.size(), exp_if.size());
    end
    exp_req.delete();
    exp_if.delete();
    cache_block = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_ready(input logic [31:0] a);
    int n = 0;
    while (!(bus.ic_resp_ready && bus.ic_req_addr == a) && n < 50) begin
      step();
      n++;
    end
    tests++;
    assert (n < 50) else begin
      fails++;
      $error("FAIL wait_ready: observed no completion of %h within %0d cycles, expected one", a, n);
    end
  endtask

  task automatic redirect_once(input logic [31:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = tgt;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  // Runs until every queued expectation is consumed, then freezes the cache.
  task automatic drain();
    int n = 0;
    while ((exp_req.size() != 0 || exp_if.size() != 0) && n < 100) begin
      if (exp_req.size() == 0) cache_block = 1'b1;
      step();
      n++;
    end
    cache_block = 1'b1;
    tests++;
    assert (n < 100) else begin
      fails++;
      $error("FAIL drain: observed %0d req / %0d if_id still pending, expected 0/0",
             exp_req.size(), exp_if.size());
    end
  endtask

  initial begin : cache_model
    logic        prev_vld;
    logic        prev_rdy;
    logic [31:0] prev_addr;
    int          cnt;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_addr = 32'h0;
    cnt = 0;
    bus.ic_resp_ready = 1'b0;
    bus.ic_resp_data = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && prev_vld && !prev_rdy) begin
        check("req_valid_hold", {31'b0, bus.ic_req_valid}, 32'd1);
        check("req_addr_hold", bus.ic_req_addr, prev_addr);
      end
      if (bus.ic_resp_ready || rst) cnt = 0;
      bus.ic_resp_ready = 1'b0;
      if (!rst && bus.ic_req_valid) begin
        if (cnt >= cache_lat && !cache_block) begin
          bus.ic_resp_ready = 1'b1;
          bus.ic_resp_data = inst_of(bus.ic_req_addr);
          tests++;
          assert (exp_req.size() > 0) else begin
            fails++;
            $error("FAIL req_unexpected: observed completion at %h, expected none", bus.ic_req_addr);
          end
          if (exp_req.size() > 0) check("req_addr", bus.ic_req_addr, exp_req.pop_front());
        end else begin
          cnt++;
        end
      end
      prev_vld = bus.ic_req_valid && !rst;
      prev_rdy = bus.ic_resp_ready;
      prev_addr = bus.ic_req_addr;
    end
  end

  initial begin : if_id_monitor
    logic        prev_vld;
    logic [31:0] e;
    prev_vld = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_vld = 1'b0;
      end else begin
        // A new load shows as valid after an empty slot or after decode accepted the old one.
        if (bus.if_id_valid && (!prev_vld || !bus.id_stall)) begin
          tests++;
          assert (exp_if.size() > 0) else begin
            fails++;
            $error("FAIL if_id_unexpected: observed pc %h, expected no delivery", bus.if_id_pc);
          end
          if (exp_if.size() > 0) begin
            e = exp_if.pop_front();
            check("if_id_pc", bus.if_id_pc, e);
            check("if_id_inst", bus.if_id_inst, inst_of(e));
          end
        end else if (!bus.if_id_valid) begin
          check("if_id_nop", bus.if_id_inst, TB_NOP);
        end
        prev_vld = bus.if_id_valid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog timeout");
  end

  initial begin : stimulus
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_stall = 1'b0;

    // Sequential fetch from reset.
    reset_dut();
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_if  = '{32'h0, 32'h4, 32'h8};
    step();
    check("first_req_valid", {31'b0, bus.ic_req_valid}, 32'd1);
    check("first_req_addr", bus.ic_req_addr, 32'h0);
    drain();

    // Decode stall while 0x4 completes: skid holds it, requests pause.
    reset_dut();
    exp_req = '{32'h0, 32'h4, 32'h8};
    exp_if  = '{32'h0, 32'h4, 32'h8};
    wait_ready(32'h0);
    bus.id_stall = 1'b1;
    wait_ready(32'h4);
    step();
    check("hold_if_id_pc", bus.if_id_pc, 32'h0);
    repeat (3) begin
      check("hold_no_req", {31'b0, bus.ic_req_valid}, 32'd0);
      step();
    end
    bus.id_stall = 1'b0;
    drain();

    // Redirect while 0x8 waits on a slow cache.
    reset_dut();
    exp_req = '{32'h0, 32'h4, 32'h8, 32'h100};
    exp_if  = '{32'h0, 32'h4, 32'h100};
    wait_ready(32'h4);
    cache_block = 1'b1;
    step();
    check("wait_req_addr", bus.ic_req_addr, 32'h8);
    redirect_once(32'h100);
    repeat (3) begin
      check("discard_if_id_valid", {31'b0, bus.if_id_valid}, 32'd0);
      check("discard_req_valid", {31'b0, bus.ic_req_valid}, 32'd1);
      check("discard_req_addr", bus.ic_req_addr, 32'h8);
      step();
    end
    cache_block = 1'b0;
    drain();

    // Redirect coincident with ready: data dropped, target fetched next.
    reset_dut();
    exp_req = '{32'h0, 32'h4, 32'h200};
    exp_if  = '{32'h0, 32'h200};
    wait_ready(32'h4);
    redirect_once(32'h200);
    check("same_cycle_req_valid", {31'b0, bus.ic_req_valid}, 32'd1);
    check("same_cycle_req_addr", bus.ic_req_addr, 32'h200);
    check("same_cycle_if_id_valid", {31'b0, bus.if_id_valid}, 32'd0);
    drain();

    // Unaligned redirect target is word-aligned.
    reset_dut();
    exp_req = '{32'h0, 32'h100};
    exp_if  = '{32'h100};
    wait_ready(32'h0);
    redirect_once(32'h103);
    check("align_req_addr", bus.ic_req_addr, 32'h100);
    drain();

    // pc wraps from the top of the address space.
    reset_dut();
    exp_req = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    exp_if  = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    wait_ready(32'h0);
    redirect_once(32'hFFFF_FFFB);
    check("wrap_req_addr", bus.ic_req_addr, 32'hFFFF_FFF8);
    drain();

    // Reset while a discard is pending abandons it and restarts at RESET_PC.
    reset_dut();
    cache_block = 1'b1;
    step();
    check("pre_discard_req_valid", {31'b0, bus.ic_req_valid}, 32'd1);
    check("pre_discard_req_addr", bus.ic_req_addr, 32'h0);
    redirect_once(32'h40);
    check("discard_hold_addr", bus.ic_req_addr, 32'h0);
    rst = 1'b1;
    step();
    check_reset_vals("mid_rst");
    rst = 1'b0;
    cache_block = 1'b0;
    exp_req = '{32'h0, 32'h4};
    exp_if  = '{32'h0, 32'h4};
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage sitting directly upstream of the instruction cache: owns the PC, issues one fetch request at a time over the cache's valid/ready handshake, and delivers fetched instructions into the IF/ID pipeline register. Handles decode-stage back-pressure with a one-entry skid slot. Handles branch/jump redirects, including redirects that arrive while a cache request is outstanding; such requests cannot be aborted and are drained and discarded.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction value driven when if_id_valid is 0.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- ic_req_valid  out  1  fetch request to I-cache.
- ic_req_addr  out  32  fetch address, word-aligned.
- ic_resp_data  in  32  instruction from I-cache; sampled only when ic_resp_ready=1.
- ic_resp_ready  in  1  I-cache completes the outstanding request this cycle.
- redirect_valid  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- id_stall  in  1  decode cannot accept a new instruction this cycle.
- if_id_valid  out  1  IF/ID register holds a valid instruction.
- if_id_pc  out  32  PC of if_id_inst.
- if_id_inst  out  32  fetched instruction.

## Operation
- Registers: pc (next address to fetch), req_addr (address of the request in flight), skid_pc/skid_inst, IF/ID output registers.
- States:
  - IDLE: held during reset plus one cycle after; ic_req_valid=0.
  - FETCH: request in flight; ic_req_valid=1, ic_req_addr=req_addr.
  - HOLD: skid slot occupied; no request is issued.
  - DISCARD: request in flight whose data will be dropped.
- IDLE -> FETCH unconditionally. On entry, req_addr<=pc.
- FETCH, ic_resp_ready=1, no redirect:
  - pc<=pc+4; the next request starts next cycle with req_addr<=pc+4.
  - If the IF/ID slot is free (if_id_valid=0 or id_stall=0): load if_id_pc=req_addr and if_id_inst=ic_resp_data, set if_id_valid=1, stay in FETCH.
  - Otherwise: load the skid slot and go to HOLD.
- HOLD: when id_stall=0, move skid to IF/ID (if_id_valid=1) and go to FETCH with req_addr<=pc.
- Consumption: IF/ID not reloaded while id_stall=0 -> if_id_valid<=0 and if_id_inst<=NOP_INST.
- Redirect has priority over every other event in every state except IDLE-under-rst:
  - if_id_valid<=0, skid cleared, pc<=redirect_pc&~3.
  - FETCH without ic_resp_ready in the same cycle -> DISCARD; req_addr is held.
  - FETCH with ic_resp_ready in the same cycle -> data dropped, then FETCH at the new pc.
  - HOLD -> FETCH at the new pc.
  - DISCARD -> stays in DISCARD and updates pc; goes to FETCH if ic_resp_ready is also asserted.
- DISCARD: on ic_resp_ready, drop the data and go to FETCH with req_addr<=pc.
- pc arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.

## Timing
- Reset values:
  - ic_req_valid=0, ic_req_addr=RESET_PC.
  - if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST.
  - pc=RESET_PC, skid empty, state IDLE.
- Handshake:
  - Once ic_req_valid rises, it and ic_req_addr stay constant until the cycle ic_resp_ready=1, including across redirects.
  - ic_req_valid drops for at least 0 cycles between requests. Back-to-back FETCH re-asserts it on the next cycle with the new address.
  - ic_resp_ready is accepted in any cycle, including the first cycle of the request.
- Latency: an instruction appears on if_id_* on the cycle after ic_resp_ready. The first valid request follows reset deassertion by 1 cycle.
- Throughput: the maximum is one instruction per 2 cycles when the cache responds on the cycle after valid.
- Reset mid-request: the request is abandoned with no drain. The cache is reset by the same rst.
- No combinational path from ic_resp_* to ic_req_*. All outputs are registered except ic_req_valid, which is a state decode.

## Structure
- Shared header (alongside the existing stage header): state encodings (IDLE, FETCH, HOLD, DISCARD), NOP_INST value, RESET_PC default.
- One sub-module: if_skid_slot. It is a one-entry pc/inst holding register with load/unload/clear and a full flag.

## Test plan
- Reset release with a cache that returns ready 1 cycle after valid -> requests at addresses 0x0, 0x4, 0x8. if_id_pc sequence 0x0, 0x4, 0x8 with matching instructions, if_id_valid pulses as expected.
- id_stall=1 asserted while the fetch of 0x4 completes -> skid holds 0x4, ic_req_valid=0 until the stall clears. Then 0x4 is presented and fetch resumes at 0x8 with no loss or duplication.
- redirect_valid with redirect_pc=0x100 while request 0x8 waits (ready held low 3 cycles) -> addr 0x8 stays stable until ready. Data is dropped, if_id_valid=0, and the next request is 0x100.
- redirect in the same cycle as ic_resp_ready -> data dropped; the next request is the target.
- redirect_pc=0x103 -> fetch issued at 0x100.
- pc=0xFFFF_FFFC -> the next request is 0x0.
- rst asserted while DISCARD is pending -> next cycle shows all outputs at reset values, and fetch restarts at RESET_PC.
